inv_haar_stream: RTL and testbench
==================================

INV_HAAR_STREAM -- requirements
Module: inv_haar_stream

Interface
REQ-001 Parameter WIDTH, default 20, output image width in pixels; SHALL be even and >= 2.
REQ-002 Parameter HEIGHT, default 30, output image height in rows; SHALL be >= 1.
REQ-003 Parameter CH, default 3, colour channels per pixel.
REQ-004 Parameter COEF_W, default 10, signed coefficient width per channel.
REQ-005 Parameter PIX_W, default 8, unsigned output sample width per channel.
REQ-006 Port HCLK  in  1  single clock; one clock, all logic on rising edge.
REQ-007 Port HRESET  in  1  reset, synchronous, active-high.
REQ-008 Port in_valid  in  1  coefficient pair valid.
REQ-009 Port in_ready  out  1  coefficient pair accepted when in_valid && in_ready.
REQ-010 Port in_l  in  CH*COEF_W  low-band coefficients, channel c at [c*COEF_W +: COEF_W].
REQ-011 Port in_h  in  CH*COEF_W  high-band coefficients, same packing.
REQ-012 Port out_valid  out  1  reconstructed pixel valid.
REQ-013 Port out_ready  in  1  downstream accepts pixel.
REQ-014 Port out_pix  out  CH*PIX_W  reconstructed pixel, channel c at [c*PIX_W +: PIX_W].
REQ-015 Port out_sof / out_eol / out_eof  out  1 each  start-of-frame, end-of-line, end-of-frame tags qualified by out_valid.
REQ-016 Port frame_done  out  1  one-cycle pulse after the last pixel of a frame is handshaked.

Function
REQ-017 Per channel: even = L+H, odd = L-H, computed signed at COEF_W+1 bits, no overflow.
REQ-018 Sample conversion: result < 0 -> 0; result > 2^PIX_W-1 -> 2^PIX_W-1; otherwise low PIX_W bits.
REQ-019 FSM states S_IDLE, S_EVEN, S_ODD; L/H captured into registers on input handshake.
REQ-020 S_IDLE: in_ready=1, out_valid=0; in_valid -> capture, go S_EVEN.
REQ-021 S_EVEN: in_ready=0, out_valid=1, out_pix=even; out_ready -> S_ODD; else hold.
REQ-022 S_ODD: out_valid=1, out_pix=odd, in_ready=out_ready; out_ready&&in_valid -> capture new pair, S_EVEN; out_ready&&!in_valid -> S_IDLE; !out_ready -> hold.
REQ-023 Latency: even pixel valid the cycle after input acceptance; sustained throughput one pair per 2 cycles, no bubble.
REQ-024 While out_valid && !out_ready, out_pix and all tags SHALL remain stable.
REQ-025 Column x (0..WIDTH-1) and row y (0..HEIGHT-1) advance on each output handshake; x wraps to 0 with y+1; y wraps to 0 after HEIGHT-1.
REQ-026 out_sof = (x==0 && y==0); out_eol = (x==WIDTH-1); out_eof = out_eol && (y==HEIGHT-1).
REQ-027 frame_done SHALL assert exactly one cycle, the cycle after the out_eof handshake; next frame proceeds without restart.

Reset
REQ-028 While HRESET=1 at a rising edge: state S_IDLE, x=y=0, captured L/H=0, frame_done=0.
REQ-029 While HRESET is high: in_ready=0, out_valid=0, out_pix=0, tags=0.
REQ-030 Reset mid-frame SHALL discard any captured pair and restart at x=0, y=0.

Configuration
REQ-031 Macro INV_HAAR_SAT_EN defined: conversion per REQ-018 (clamp).
REQ-032 Macro INV_HAAR_SAT_EN undefined: conversion SHALL truncate to low PIX_W bits (wrap), no clamp logic.

Structure
REQ-033 Package inv_haar_pkg SHALL hold the FSM state typedef (S_IDLE/S_EVEN/S_ODD) and the default width constants.
REQ-034 Sub-module inv_haar_butterfly (combinational, one channel: add, subtract, convert) SHALL be instantiated CH times.

Verification
REQ-035 CH=3, COEF_W=10, PIX_W=8: L=100, H=20 all channels -> out_pix 120 then 80, latency 1 cycle.
REQ-036 L=250, H=20 -> 255 then 230 with INV_HAAR_SAT_EN; 14 (0x0E) then 230 without.
REQ-037 L=-10, H=5 -> 0 then 0 with INV_HAAR_SAT_EN.
REQ-038 out_ready low 3 cycles in S_EVEN -> out_pix held at 120, in_ready=0, no extra pixel.
REQ-039 WIDTH=4, HEIGHT=2, 4 back-to-back pairs, out_ready=1 -> 8 pixels in 8 cycles; sof on pixel 1, eol on 4 and 8, eof on 8, frame_done next cycle.
REQ-040 HRESET pulsed after pixel 3 of a frame -> outputs 0 during reset; next pixel carries out_sof.

Source files
------------

// File: rtl/inv_haar_pkg.sv
// inv_haar_pkg: shared definitions for the inverse Haar stream block.
//   - state_t       : reconstruction FSM states (S_IDLE / S_EVEN / S_ODD)
//   - DEF_*         : default image geometry and sample widths
package inv_haar_pkg;

  localparam int DEF_WIDTH  = 20;
  localparam int DEF_HEIGHT = 30;
  localparam int DEF_CH     = 3;
  localparam int DEF_COEF_W = 10;
  localparam int DEF_PIX_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVEN = 2'd1,
    S_ODD  = 2'd2
  } state_t;

endpackage

// File: rtl/inv_haar_stream_if.sv
// inv_haar_stream_if: coefficient-in / pixel-out stream bundle.
//   in_valid/in_ready, in_l, in_h      : low/high-band coefficient pair stream
//   out_valid/out_ready, out_pix       : reconstructed pixel stream
//   out_sof/out_eol/out_eof            : frame position tags (qualified by out_valid)
//   frame_done                         : one-cycle pulse after the last pixel of a frame
// Modports: slave = the reconstruction block, master = source/sink driving it.
interface inv_haar_stream_if
  import inv_haar_pkg::*;
#(
  parameter int CH     = DEF_CH,
  parameter int COEF_W = DEF_COEF_W,
  parameter int PIX_W  = DEF_PIX_W
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [CH*COEF_W-1:0]  in_l;
  logic [CH*COEF_W-1:0]  in_h;
  logic                  out_valid;
  logic                  out_ready;
  logic [CH*PIX_W-1:0]   out_pix;
  logic                  out_sof;
  logic                  out_eol;
  logic                  out_eof;
  logic                  frame_done;

  modport slave (
    input  in_valid, in_l, in_h, out_ready,
    output in_ready, out_valid, out_pix, out_sof, out_eol, out_eof, frame_done
  );

  modport master (
    output in_valid, in_l, in_h, out_ready,
    input  in_ready, out_valid, out_pix, out_sof, out_eol, out_eof, frame_done
  );

endinterface

// File: rtl/inv_haar_butterfly.sv
// inv_haar_butterfly: one-channel inverse Haar butterfly (combinational).
//   l, h      : signed low/high-band coefficients
//   even_pix  : converted L+H
//   odd_pix   : converted L-H
// Macro INV_HAAR_SAT_EN: defined -> clamp to [0, 2^PIX_W-1];
//                        undefined -> keep the low PIX_W bits (wrap).
module inv_haar_butterfly #(
  parameter int COEF_W = 10,
  parameter int PIX_W  = 8
) (
  input  logic signed [COEF_W-1:0] l,
  input  logic signed [COEF_W-1:0] h,
  output logic        [PIX_W-1:0]  even_pix,
  output logic        [PIX_W-1:0]  odd_pix
);

`ifdef INV_HAAR_SAT_EN
  localparam int PMAX = (1 << PIX_W) - 1;

  logic signed [COEF_W:0] sum;
  logic signed [COEF_W:0] diff;

  // One guard bit makes both results exact.
  assign sum  = {l[COEF_W-1], l} + {h[COEF_W-1], h};
  assign diff = {l[COEF_W-1], l} - {h[COEF_W-1], h};

  function automatic logic [PIX_W-1:0] clamp(input logic signed [COEF_W:0] v);
    int vi;
    vi = int'(v);
    if (vi < 0)         clamp = '0;
    else if (vi > PMAX) clamp = '1;
    else                clamp = v[PIX_W-1:0];
  endfunction

  always_comb begin
    even_pix = clamp(sum);
    odd_pix  = clamp(diff);
  end
`else
  assign even_pix = PIX_W'({l[COEF_W-1], l} + {h[COEF_W-1], h});
  assign odd_pix  = PIX_W'({l[COEF_W-1], l} - {h[COEF_W-1], h});
`endif

endmodule

// File: rtl/inv_haar_stream.sv
// inv_haar_stream: streaming inverse Haar reconstruction. Each accepted
// coefficient pair (L,H) yields two pixels: even = L+H, then odd = L-H,
// tagged with frame position (sof/eol/eof) and a frame_done pulse.
//   HCLK   : clock, rising edge
//   HRESET : synchronous active-high reset
//   bus    : inv_haar_stream_if.slave (coefficient in, pixel out, tags)
// Macro INV_HAAR_SAT_EN selects clamping instead of wrapping conversion.
module inv_haar_stream
  import inv_haar_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int CH     = DEF_CH,
  parameter int COEF_W = DEF_COEF_W,
  parameter int PIX_W  = DEF_PIX_W
) (
  input  logic              HCLK,
  input  logic              HRESET,
  inv_haar_stream_if.slave  bus
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  state_t               state_q, state_d;
  logic [CH*COEF_W-1:0] l_q, l_d, h_q, h_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic                 frame_done_q, frame_done_d;

  logic [CH*PIX_W-1:0]  even_w, odd_w;
  logic                 in_ready_w, out_valid_w, in_hs, out_hs;
  logic                 sof_w, eol_w, eof_w;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    inv_haar_butterfly #(
      .COEF_W (COEF_W),
      .PIX_W  (PIX_W)
    ) u_bf (
      .l        (l_q[c*COEF_W +: COEF_W]),
      .h        (h_q[c*COEF_W +: COEF_W]),
      .even_pix (even_w[c*PIX_W +: PIX_W]),
      .odd_pix  (odd_w[c*PIX_W +: PIX_W])
    );
  end

  // Handshake decode; in S_ODD the next pair is taken in the same cycle the
  // odd pixel leaves, which is what gives one pair per two cycles.
  always_comb begin
    in_ready_w  = 1'b0;
    out_valid_w = 1'b0;
    case (state_q)
      S_IDLE:  in_ready_w = 1'b1;
      S_EVEN:  out_valid_w = 1'b1;
      S_ODD: begin
        out_valid_w = 1'b1;
        in_ready_w  = bus.out_ready;
      end
      default: ;
    endcase
  end

  assign in_hs  = bus.in_valid && in_ready_w;
  assign out_hs = out_valid_w && bus.out_ready;
  assign sof_w  = (x_q == '0) && (y_q == '0);
  assign eol_w  = (x_q == X_LAST);
  assign eof_w  = eol_w && (y_q == Y_LAST);

  always_comb begin
    state_d      = state_q;
    l_d          = l_q;
    h_d          = h_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = out_hs && eof_w;

    if (in_hs) begin
      l_d = bus.in_l;
      h_d = bus.in_h;
    end

    case (state_q)
      S_IDLE: if (bus.in_valid) state_d = S_EVEN;
      S_EVEN: if (bus.out_ready) state_d = S_ODD;
      S_ODD:  if (bus.out_ready) state_d = bus.in_valid ? S_EVEN : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (out_hs) begin
      if (eol_w) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= S_IDLE;
      l_q          <= '0;
      h_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      l_q          <= l_d;
      h_q          <= h_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Outputs are forced quiet for the whole reset interval, not just after
  // the first reset edge.
  assign bus.in_ready   = !HRESET && in_ready_w;
  assign bus.out_valid  = !HRESET && out_valid_w;
  assign bus.out_pix    = HRESET ? '0 : ((state_q == S_ODD) ? odd_w : even_w);
  assign bus.out_sof    = !HRESET && out_valid_w && sof_w;
  assign bus.out_eol    = !HRESET && out_valid_w && eol_w;
  assign bus.out_eof    = !HRESET && out_valid_w && eof_w;
  assign bus.frame_done = !HRESET && frame_done_q;

endmodule

// File: tb/tb_inv_haar_stream.sv
// tb_inv_haar_stream: self-checking bench for inv_haar_stream with a
// 4x2 frame, 3 channels, 10-bit coefficients and 8-bit pixels.
module tb_inv_haar_stream;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int CH   = 3;
  localparam int CW   = 10;
  localparam int PW   = 8;
  localparam int NPIX = W * H;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  inv_haar_stream_if #(.CH(CH), .COEF_W(CW), .PIX_W(PW)) bus ();

  inv_haar_stream #(
    .WIDTH(W), .HEIGHT(H), .CH(CH), .COEF_W(CW), .PIX_W(PW)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int pos    = 0;   // expected frame position of the next output pixel

  logic [2:0] tags;
  assign tags = {bus.out_sof, bus.out_eol, bus.out_eof};

  // ---------------- reference model ----------------
  function automatic int conv(input int v);
`ifdef INV_HAAR_SAT_EN
    if (v < 0) return 0;
    if (v > (1 << PW) - 1) return (1 << PW) - 1;
    return v;
`else
    return v & ((1 << PW) - 1);
`endif
  endfunction

  function automatic logic [CH*PW-1:0] model_pix(input logic [CH*CW-1:0] l,
                                                 input logic [CH*CW-1:0] h,
                                                 input bit odd);
    logic [CH*PW-1:0] res;
    int a, b, q;
    res = '0;
    for (int c = 0; c < CH; c++) begin
      a = $signed(l[c*CW +: CW]);
      b = $signed(h[c*CW +: CW]);
      q = conv(odd ? a - b : a + b);
      res[c*PW +: PW] = q[PW-1:0];
    end
    return res;
  endfunction

  function automatic logic [2:0] exp_tags(input int p);
    int x, y;
    x = p % W;
    y = p / W;
    return {(x == 0 && y == 0), (x == W - 1), (x == W - 1 && y == H - 1)};
  endfunction

  function automatic logic [CH*CW-1:0] splat(input int v);
    logic [CH*CW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*CW +: CW] = CW'(v);
    return r;
  endfunction

  function automatic logic [CH*PW-1:0] splat_pix(input int v);
    logic [CH*PW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*PW +: PW] = PW'(v);
    return r;
  endfunction

  function automatic logic [CH*CW-1:0] rand_coef();
    logic [CH*CW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*CW +: CW] = CW'($urandom);
    return r;
  endfunction

  task automatic cyc();
    @(posedge HCLK);
    #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    HRESET = 1'b1;
    bus.in_valid = 1'b1; bus.in_l = splat(100); bus.in_h = splat(20);
    bus.out_ready = 1'b1;
    cyc(); cyc();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, expected 0 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.out_pix !== '0 || tags !== 3'b000 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: pix=%h tags=%b frame_done=%b, expected 0 000 0", bus.out_pix, tags, bus.frame_done);
    end
    HRESET = 1'b0;
    bus.in_valid = 1'b0;
    cyc();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: in_ready=%b out_valid=%b, expected 1 0", bus.in_ready, bus.out_valid);
    end
    pos = 0;
  endtask

  task automatic test_known_pair(input string name, input int l, input int h,
                                 input int e0, input int e1);
    bus.in_l = splat(l); bus.in_h = splat(h);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pix !== splat_pix(e0) || tags !== exp_tags(pos)) begin
      errors++;
      $display("FAIL %s_even: valid=%b pix=%h tags=%b, expected 1 %h %b",
               name, bus.out_valid, bus.out_pix, tags, splat_pix(e0), exp_tags(pos));
    end
    pos = (pos + 1) % NPIX;
    cyc();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pix !== splat_pix(e1) || tags !== exp_tags(pos)) begin
      errors++;
      $display("FAIL %s_odd: valid=%b pix=%h tags=%b, expected 1 %h %b",
               name, bus.out_valid, bus.out_pix, tags, splat_pix(e1), exp_tags(pos));
    end
    pos = (pos + 1) % NPIX;
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: out_valid=%b, expected 0", name, bus.out_valid);
    end
  endtask

  task automatic test_stall();
    bus.in_l = splat(100); bus.in_h = splat(20);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    cyc();
    // a different pair is offered during the stall and must not be taken
    bus.in_l = splat(1); bus.in_h = splat(1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pix !== splat_pix(120) ||
          bus.in_ready !== 1'b0 || tags !== exp_tags(pos)) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b pix=%h in_ready=%b tags=%b, expected 1 %h 0 %b",
                 i, bus.out_valid, bus.out_pix, bus.in_ready, tags, splat_pix(120), exp_tags(pos));
      end
      cyc();
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_pix !== splat_pix(120)) begin
      errors++;
      $display("FAIL stall_release: pix=%h, expected %h", bus.out_pix, splat_pix(120));
    end
    cyc();
    pos = (pos + 1) % NPIX;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pix !== splat_pix(80) || tags !== exp_tags(pos)) begin
      errors++;
      $display("FAIL stall_odd: valid=%b pix=%h tags=%b, expected 1 %h %b",
               bus.out_valid, bus.out_pix, tags, splat_pix(80), exp_tags(pos));
    end
    cyc();
    pos = (pos + 1) % NPIX;
    checks++;
    if (bus.frame_done !== (pos == 0) || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_frame_done: frame_done=%b out_valid=%b, expected %b 0",
               bus.frame_done, bus.out_valid, pos == 0);
    end
    cyc();
    checks++;
    if (bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_width: frame_done=%b, expected 0", bus.frame_done);
    end
  endtask

  task automatic test_stream(input string name, input int npairs, input bit stall);
    logic [CH*PW-1:0] q[$];
    logic [CH*PW-1:0] prev_pix;
    logic [2:0]       prev_tags, t;
    bit   fd_exp, prev_stall, acc, hs;
    int   sent, got, cyc_n, first_hs, last_hs;
    fd_exp = 1'b0; prev_stall = 1'b0; prev_pix = '0; prev_tags = '0;
    sent = 0; got = 0; cyc_n = 0; first_hs = -1; last_hs = -1;
    bus.out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    bus.in_valid  = (sent < npairs) && (!stall || $urandom_range(0, 3) != 0);
    bus.in_l = rand_coef(); bus.in_h = rand_coef();
    while (got < 2 * npairs && cyc_n < 4000) begin
      #1;
      checks++;
      if (bus.frame_done !== fd_exp) begin
        errors++;
        $display("FAIL %s_frame_done: cycle %0d frame_done=%b, expected %b", name, cyc_n, bus.frame_done, fd_exp);
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0 || bus.out_pix !== q[0] || tags !== exp_tags(pos)) begin
          errors++;
          $display("FAIL %s_pixel: cycle %0d pix=%h tags=%b, expected %h %b (queued %0d)",
                   name, cyc_n, bus.out_pix, tags, (q.size() != 0) ? q[0] : '0, exp_tags(pos), q.size());
        end
      end
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pix !== prev_pix || tags !== prev_tags) begin
          errors++;
          $display("FAIL %s_hold: cycle %0d valid=%b pix=%h tags=%b, expected 1 %h %b",
                   name, cyc_n, bus.out_valid, bus.out_pix, tags, prev_pix, prev_tags);
        end
      end
      acc = bus.in_valid && bus.in_ready;
      hs  = bus.out_valid && bus.out_ready;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_pix   = bus.out_pix;
      prev_tags  = tags;
      t = exp_tags(pos);
      fd_exp = hs && t[0];
      if (hs) begin
        if (q.size() != 0) void'(q.pop_front());
        pos = (pos + 1) % NPIX;
        got++;
        if (first_hs < 0) first_hs = cyc_n;
        last_hs = cyc_n;
      end
      if (acc) begin
        q.push_back(model_pix(bus.in_l, bus.in_h, 1'b0));
        q.push_back(model_pix(bus.in_l, bus.in_h, 1'b1));
        sent++;
      end
      @(posedge HCLK);
      #1;
      cyc_n++;
      bus.out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (acc || !bus.in_valid) begin
        bus.in_valid = (sent < npairs) && (!stall || $urandom_range(0, 3) != 0);
        bus.in_l = rand_coef(); bus.in_h = rand_coef();
      end
    end
    checks++;
    if (got != 2 * npairs) begin
      errors++;
      $display("FAIL %s_count: got %0d pixels, expected %0d", name, got, 2 * npairs);
    end
    if (!stall) begin
      checks++;
      if (last_hs - first_hs != 2 * npairs - 1) begin
        errors++;
        $display("FAIL %s_throughput: %0d cycles first-to-last pixel, expected %0d",
                 name, last_hs - first_hs, 2 * npairs - 1);
      end
    end
    #1;
    checks++;
    if (bus.frame_done !== fd_exp) begin
      errors++;
      $display("FAIL %s_final_frame_done: frame_done=%b, expected %b", name, bus.frame_done, fd_exp);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cyc();
  endtask

  task automatic test_reset_midframe();
    bus.in_l = splat(7); bus.in_h = splat(3);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cyc(); cyc(); cyc(); cyc();   // pixels 1..3 handshaked, pixel 4 pending
    HRESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_pix !== '0 ||
          tags !== 3'b000 || bus.frame_done !== 1'b0) begin
        errors++;
        $display("FAIL midreset_out%0d: in_ready=%b valid=%b pix=%h tags=%b fd=%b, expected 0 0 0 000 0",
                 i, bus.in_ready, bus.out_valid, bus.out_pix, tags, bus.frame_done);
      end
      cyc();
    end
    HRESET = 1'b0;
    bus.in_l = splat(100); bus.in_h = splat(20);
    cyc();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sof !== 1'b1 || bus.out_pix !== splat_pix(120)) begin
      errors++;
      $display("FAIL midreset_restart: valid=%b sof=%b pix=%h, expected 1 1 %h",
               bus.out_valid, bus.out_sof, bus.out_pix, splat_pix(120));
    end
    cyc(); cyc();
    pos = 2;
  endtask

  initial begin
    HRESET = 1'b1;
    bus.in_valid = 1'b0; bus.in_l = '0; bus.in_h = '0; bus.out_ready = 1'b0;
    test_reset();
    test_known_pair("basic", 100, 20, 120, 80);
`ifdef INV_HAAR_SAT_EN
    test_known_pair("sat_hi", 250, 20, 255, 230);
    test_known_pair("sat_lo", -10, 5, 0, 0);
`else
    test_known_pair("wrap_hi", 250, 20, 14, 230);
    test_known_pair("wrap_lo", -10, 5, 251, 241);
`endif
    test_stall();
    test_stream("back_to_back", 4, 1'b0);
    test_stream("random", 40, 1'b1);
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
